// File: rtl/dec_rr_arbiter_pkg.sv
// Shared types and sizes for the round-robin arbiter in front of the 2-to-4 decoder.
package dec_rr_arbiter_pkg;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 enable decoder: one-hot Z selected by {B,A}, all zero when En is low.
module dec2to4 (
  input  logic       A,
  input  logic       B,
  input  logic       En,
  output logic [3:0] Z
);

  always_comb begin
    Z = 4'b0000;
    if (En) begin
      Z[{B, A}] = 1'b1;
    end
  end

endmodule

// File: rtl/dec_rr_arbiter.sv
// Round-robin owner selection for the shared decoder, with bounded hold and a one-cycle dead gap.
module dec_rr_arbiter
  import dec_rr_arbiter_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   sel,
  output logic               en,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

  arb_state_e         state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               en_q, en_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic [SEL_W-1:0]   winner_c;

  // First set request after the previous owner; the previous owner itself is checked last.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   prev);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] win;
    logic             found;
    win   = prev;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = prev + SEL_W'(i);
      if (!found && r[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  assign winner_c = rr_pick(req, last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= SEL_W'(NUM_REQ - 1);
      cnt_q     <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    en_d      = 1'b0;
    busy_d    = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (|req) begin
          state_d = ST_GRANT;
          sel_d   = winner_c;
          last_d  = winner_c;
          cnt_d   = '0;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        cnt_d  = cnt_q + CW'(1);
        en_d   = 1'b1;
        busy_d = 1'b1;
        // Normal release wins over the hold limit when both hit together.
        if (!req[sel_q]) begin
          state_d = ST_GAP;
          en_d    = 1'b0;
          busy_d  = 1'b0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d   = ST_GAP;
          en_d      = 1'b0;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign sel     = sel_q;
  assign en      = en_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

  dec2to4 u_dec (
    .A  (sel_q[0]),
    .B  (sel_q[1]),
    .En (en_q),
    .Z  (grant)
  );

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Bench for dec_rr_arbiter: transaction-level owner model checked every cycle, plus directed scenarios.
module tb_dec_rr_arbiter;

  localparam int HOLD = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [1:0] sel;
  logic       en;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_tests = 0;
  int n_fail  = 0;

  dec_rr_arbiter #(.HOLD_MAX(HOLD), .CW(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .sel     (sel),
    .en      (en),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  // Model: who owns the decoder, for how many cycles, and who owned it last.
  int       m_owner = -1;
  int       m_len   = 0;
  int       m_last  = 3;
  int       m_sel   = 0;
  bit       m_to    = 1'b0;
  int       m_cand;
  bit       m_found;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_len   = 0;
      m_last  = 3;
      m_sel   = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner]) begin
          m_owner = -1;
        end else if (m_len == HOLD) begin
          m_owner = -1;
          m_to    = 1'b1;
        end else begin
          m_len = m_len + 1;
        end
      end else if (req != 4'b0000) begin
        m_found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          m_cand = (m_last + k) % 4;
          if (!m_found && req[m_cand]) begin
            m_found = 1'b1;
            m_owner = m_cand;
          end
        end
        m_sel  = m_owner;
        m_last = m_owner;
        m_len  = 1;
      end
    end
  end

  // Per-cycle comparison against the model plus grant-safety properties.
  logic [8:0] exp_vec;
  logic [8:0] act_vec;
  logic [3:0] exp_grant;
  logic       exp_en;
  logic       prev_en  = 1'b0;
  logic [1:0] prev_sel = 2'd0;

  always @(negedge clk) begin
    exp_en    = (m_owner >= 0);
    exp_grant = exp_en ? 4'(1 << m_sel) : 4'b0000;
    exp_vec   = {2'(m_sel), exp_en, exp_grant, exp_en, m_to};
    act_vec   = {sel, en, grant, busy, timeout};
    n_tests++;
    if (act_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL model t=%0t: got {sel,en,grant,busy,to}=%b expected %b", $time, act_vec, exp_vec);
    end
    n_tests++;
    if ($countones(grant) > 1 || (!en && grant != 4'b0000)) begin
      n_fail++;
      $display("FAIL onehot t=%0t: got grant=%b en=%b required one-hot or zero", $time, grant, en);
    end
    n_tests++;
    if (prev_en && en && sel != prev_sel) begin
      n_fail++;
      $display("FAIL gap t=%0t: got owner %0d right after owner %0d, required a gap", $time, sel, prev_sel);
    end
    prev_en  = en;
    prev_sel = sel;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int own_list[$];
  int exp_own[5] = '{0, 1, 2, 3, 0};
  int n_to;
  int n_en;
  logic p_en;

  initial begin
    // Reset state and single requester 2.
    do_reset();
    chk("rst_en", int'(en), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sel", int'(sel), 0);
    req = 4'b0100;
    tick();
    chk("t1_sel", int'(sel), 2);
    chk("t1_en", int'(en), 1);
    chk("t1_grant", int'(grant), 4);
    chk("t1_busy", int'(busy), 1);

    // Sustained all-request traffic rotates owners with forced releases.
    do_reset();
    req  = 4'b1111;
    n_to = 0;
    n_en = 0;
    p_en = 1'b0;
    own_list.delete();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (en && !p_en) own_list.push_back(int'(sel));
      if (timeout) n_to++;
      if (en) n_en++;
      p_en = en;
    end
    chk("t2_ngrants", own_list.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < own_list.size()) chk($sformatf("t2_owner%0d", i), own_list[i], exp_own[i]);
    end
    chk("t2_timeouts", n_to, 5);
    chk("t2_en_cycles", n_en, 15);

    // Release coinciding with the hold limit is a normal release.
    do_reset();
    req = 4'b0010;
    tick();
    chk("t3_sel", int'(sel), 1);
    tick();
    tick();
    req = 4'b0000;
    tick();
    chk("t3_en", int'(en), 0);
    chk("t3_timeout", int'(timeout), 0);
    chk("t3_busy", int'(busy), 0);

    // Sole requester re-requests during the gap.
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("t4_gap_en", int'(en), 0);
    req = 4'b0100;
    tick();
    chk("t4_regrant_en", int'(en), 1);
    chk("t4_regrant_sel", int'(sel), 2);
    chk("t4_regrant_grant", int'(grant), 4);

    // Asynchronous reset mid-grant, then search restarts at requester 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk("t5_sel3", int'(sel), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_en", int'(en), 0);
    chk("t5_async_grant", int'(grant), 0);
    chk("t5_async_busy", int'(busy), 0);
    req = 4'b1001;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_after_sel", int'(sel), 0);
    chk("t5_after_grant", int'(grant), 1);

    // Random traffic with sticky request patterns.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      tick();
    end
    req = 4'b0000;
    tick();
    tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
